// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/func constants, the instruction fetch FSM
// state encoding, the default reset PC and a branch offset helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // FETCH: may issue; WAIT: response owed to the live path;
  // DROP: response owed to a flushed path and must be thrown away.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } ifetch_state_e;

  // Word offset of a beq immediate, sign-extended and scaled to bytes.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: DEPTH entries of {instr, pc}. The head entry is read
// straight out of flops so the decode stage sees a registered output.
// Flush beats push and pop; push on a full buffer is accepted only together
// with a pop.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_q];

  // Pointer/count/storage update; reset also clears storage so the head
  // reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: holds the PC, issues one outstanding word
// read to imem, buffers returned words and redirects on jr/j/jal/taken beq
// when the decode stage consumes the head instruction.
// Optional: define IFETCH_PERF_EN to add perf_fetch_cnt/perf_flush_cnt.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic        jumpreg,
  input  logic [31:0] busA,
  input  logic        jumplink,
  output logic [31:0] link_addr
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  ifetch_state_e state_q;
  logic [31:0]   fetch_pc_q, req_pc_q;
  logic          consume, redirect, push;
  logic [31:0]   pc_plus4, target;
  logic          fifo_full, fifo_empty;
  logic [63:0]   head;
  logic          unused_bits;

  // jumplink only qualifies link_addr downstream; busA low bits are masked.
  assign unused_bits = ^{jumplink, busA[1:0]};

  assign consume     = inst_valid & inst_ready;
  assign pc_plus4    = inst_pc + 32'd4;
  assign link_addr   = pc_plus4;
  assign inst_valid  = ~fifo_empty;
  assign Instruction = head[63:32];
  assign inst_pc     = head[31:0];

  // Redirect target for the instruction being consumed, jr highest priority.
  always_comb begin
    redirect = 1'b0;
    target   = pc_plus4;
    if (consume) begin
      if (jumpreg) begin
        redirect = 1'b1;
        target   = {busA[31:2], 2'b00};
      end else if (jump) begin
        redirect = 1'b1;
        target   = {pc_plus4[31:28], Instruction[25:0], 2'b00};
      end else if (branch && zero) begin
        redirect = 1'b1;
        target   = pc_plus4 + br_offset(Instruction[15:0]);
      end
    end
  end

  // A redirect cycle never issues: the address would belong to the old path.
  assign imem_req  = ~rst & (state_q == S_FETCH) & ~fifo_full & ~redirect;
  assign imem_addr = fetch_pc_q;
  assign push      = (state_q == S_WAIT) & imem_rvalid & ~redirect;

  ifetch_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (consume),
    .flush (redirect),
    .wdata ({imem_rdata, req_pc_q}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Fetch FSM with PC tracking; a redirect during WAIT turns the owed
  // response into one that must be dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      if (redirect) fetch_pc_q <= target;
      case (state_q)
        S_FETCH: begin
          if (imem_req && imem_ready) begin
            state_q  <= S_WAIT;
            req_pc_q <= fetch_pc_q;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_q <= S_FETCH;
            if (!redirect) fetch_pc_q <= fetch_pc_q + 32'd4;
          end else if (redirect) begin
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_flush_q;
  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (push)     perf_fetch_q <= perf_fetch_q + 32'd1;
      if (redirect) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end
`endif

endmodule
